// File: rtl/ldpc_rx_pkg.sv
// Shared constants and types for the LDPC receive-side word path.
package ldpc_rx_pkg;

  // DVB-S2 short frame: codeword length and information length per code rate.
  localparam int unsigned N_SHORT      = 16200;
  localparam int unsigned K_SHORT_1_4  = 3240;
  localparam int unsigned K_SHORT_1_3  = 5400;
  localparam int unsigned K_SHORT_2_5  = 6480;
  localparam int unsigned K_SHORT_1_2  = 7200;
  localparam int unsigned K_SHORT_3_5  = 9720;
  localparam int unsigned K_SHORT_2_3  = 10800;
  localparam int unsigned K_SHORT_3_4  = 11880;
  localparam int unsigned K_SHORT_4_5  = 12600;
  localparam int unsigned K_SHORT_5_6  = 13320;
  localparam int unsigned K_SHORT_8_9  = 14400;

  // Frame phase: systematic words are serialised, parity words are dropped.
  typedef enum logic {
    SYS = 1'b0,
    PAR = 1'b1
  } phase_t;

  // Counter width able to hold 0..n-1 (at least one bit).
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ldpc_systematic_deframer_if.sv
// Word-in / bit-out handshake bundle of the systematic deframer.
interface ldpc_systematic_deframer_if #(
  parameter int unsigned DATA_W = 8
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              bit_out;
  logic              bit_valid;
  logic              bit_ready;
  logic              bit_sof;
  logic              bit_eof;
  logic              frame_done;

  // Codeword source plus bit consumer side.
  modport master (
    output in_valid, in_data, bit_ready,
    input  in_ready, bit_out, bit_valid, bit_sof, bit_eof, frame_done
  );

  // Deframer side.
  modport slave (
    input  in_valid, in_data, bit_ready,
    output in_ready, bit_out, bit_valid, bit_sof, bit_eof, frame_done
  );
endinterface

// File: rtl/ldpc_word_serializer.sv
// MSB-first word serializer with frame-position tags and a valid/ready bit port.
module ldpc_word_serializer
  import ldpc_rx_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clk_enable,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_first,
  input  logic              load_last,
  input  logic              bit_ready,
  output logic              bit_out,
  output logic              bit_valid,
  output logic              bit_sof,
  output logic              bit_eof,
  output logic              busy,
  output logic              freeing
);

  localparam int unsigned       CW       = cnt_w(DATA_W);
  localparam logic [CW-1:0]     LAST_BIT = CW'(DATA_W - 1);

  logic [DATA_W-1:0] shreg;
  logic [CW-1:0]     bit_cnt;
  logic              full;
  logic              tag_first;
  logic              tag_last;
  logic              xfer;

  assign bit_valid = full & clk_enable;
  assign xfer      = bit_valid & bit_ready;
  assign bit_out   = shreg[DATA_W-1];
  assign bit_sof   = bit_valid & tag_first & (bit_cnt == '0);
  assign bit_eof   = bit_valid & tag_last & (bit_cnt == LAST_BIT);
  assign busy      = full;
  assign freeing   = xfer & (bit_cnt == LAST_BIT);

  // Shifter state: a load always wins, otherwise shift on each bit transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg     <= '0;
      bit_cnt   <= '0;
      full      <= 1'b0;
      tag_first <= 1'b0;
      tag_last  <= 1'b0;
    end else if (clk_enable) begin
      if (load) begin
        shreg     <= load_data;
        bit_cnt   <= '0;
        full      <= 1'b1;
        tag_first <= load_first;
        tag_last  <= load_last;
      end else if (xfer) begin
        shreg   <= {shreg[DATA_W-2:0], 1'b0};
        bit_cnt <= bit_cnt + CW'(1);
        if (bit_cnt == LAST_BIT) begin
          full <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/ldpc_systematic_deframer.sv
// Drops LDPC parity words and re-serialises the systematic words as a framed bit stream.
module ldpc_systematic_deframer
  import ldpc_rx_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned N_BITS = 16200,
  parameter int unsigned K_BITS = 7200
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clk_enable,
  ldpc_systematic_deframer_if.slave   bus
);

  localparam int unsigned        WPF       = N_BITS / DATA_W;
  localparam int unsigned        SPF       = K_BITS / DATA_W;
  localparam int unsigned        CNT_W     = cnt_w(WPF);
  localparam logic [CNT_W-1:0]   LAST_WORD = CNT_W'(WPF - 1);
  localparam logic [CNT_W-1:0]   LAST_SYS  = CNT_W'(SPF - 1);

  logic [CNT_W-1:0] word_cnt;
  phase_t           phase;
  logic             frame_done_q;
  logic             in_ready_c;
  logic             accept;
  logic             ser_load;
  logic             ser_busy;
  logic             ser_freeing;

  // Parity words never wait for the shifter; systematic words wait until it is
  // empty or releases its last bit this cycle. rst_n keeps ready low in reset.
  assign in_ready_c = rst_n & clk_enable &
                      ((phase == PAR) | ~ser_busy | ser_freeing);
  assign accept     = bus.in_valid & in_ready_c;
  assign ser_load   = accept & (phase == SYS);

  assign bus.in_ready   = in_ready_c;
  assign bus.frame_done = frame_done_q;

  // Frame position and phase FSM with a registered end-of-codeword pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt     <= '0;
      phase        <= SYS;
      frame_done_q <= 1'b0;
    end else if (clk_enable) begin
      frame_done_q <= 1'b0;
      if (accept) begin
        word_cnt <= (word_cnt == LAST_WORD) ? '0 : word_cnt + CNT_W'(1);
        unique case (phase)
          SYS: if (word_cnt == LAST_SYS) phase <= PAR;
          PAR: if (word_cnt == LAST_WORD) begin
            phase        <= SYS;
            frame_done_q <= 1'b1;
          end
          default: phase <= SYS;
        endcase
      end
    end
  end

  ldpc_word_serializer #(
    .DATA_W (DATA_W)
  ) u_serializer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clk_enable (clk_enable),
    .load       (ser_load),
    .load_data  (bus.in_data),
    .load_first (word_cnt == '0),
    .load_last  (word_cnt == LAST_SYS),
    .bit_ready  (bus.bit_ready),
    .bit_out    (bus.bit_out),
    .bit_valid  (bus.bit_valid),
    .bit_sof    (bus.bit_sof),
    .bit_eof    (bus.bit_eof),
    .busy       (ser_busy),
    .freeing    (ser_freeing)
  );

endmodule

// File: tb/tb_ldpc_systematic_deframer.sv
// Scoreboard bench: a small 4-bit/16-bit-frame instance and a default-parameter instance.
module tb_ldpc_systematic_deframer;

  typedef struct packed {
    logic b;
    logic sof;
    logic eof;
  } exp_t;

  localparam int LIMIT = 400;

  logic       clk;
  logic       rst_n;
  logic       clk_enable;
  logic       in_valid;
  logic [7:0] in_data;
  logic       bit_ready;
  logic       sel;

  int n_checks = 0;
  int n_errors = 0;
  int bits_out = 0;
  int fd_pulses = 0;
  int m_cnt = 0;
  logic fd_exp = 1'b0;
  logic fd_prev = 1'b0;
  exp_t q[$];

  ldpc_systematic_deframer_if #(.DATA_W(4)) bus4 ();
  ldpc_systematic_deframer_if #(.DATA_W(8)) bus8 ();

  assign bus4.in_valid  = in_valid & ~sel;
  assign bus4.in_data   = in_data[3:0];
  assign bus4.bit_ready = bit_ready;
  assign bus8.in_valid  = in_valid & sel;
  assign bus8.in_data   = in_data;
  assign bus8.bit_ready = bit_ready;

  ldpc_systematic_deframer #(.DATA_W(4), .N_BITS(16), .K_BITS(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .clk_enable(clk_enable), .bus(bus4)
  );

  ldpc_systematic_deframer #(.DATA_W(8), .N_BITS(16200), .K_BITS(7200)) dut8 (
    .clk(clk), .rst_n(rst_n), .clk_enable(clk_enable), .bus(bus8)
  );

  logic act_ir, act_bv, act_bo, act_sof, act_eof, act_fd;
  assign act_ir  = sel ? bus8.in_ready   : bus4.in_ready;
  assign act_bv  = sel ? bus8.bit_valid  : bus4.bit_valid;
  assign act_bo  = sel ? bus8.bit_out    : bus4.bit_out;
  assign act_sof = sel ? bus8.bit_sof    : bus4.bit_sof;
  assign act_eof = sel ? bus8.bit_eof    : bus4.bit_eof;
  assign act_fd  = sel ? bus8.frame_done : bus4.frame_done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      if (n_errors <= 20)
        $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model sampled mid-cycle: the queue holds exactly the bits the
  // shifter should still present, frame position tracked from accepted words.
  always @(negedge clk) begin : monitor
    int   dw, spf, wpf;
    logic xfer, acc;
    dw  = sel ? 8 : 4;
    spf = sel ? 900 : 2;
    wpf = sel ? 2025 : 4;
    if (!rst_n) begin
      q.delete();
      m_cnt  = 0;
      fd_exp = 1'b0;
      check("rst_in_ready",   act_ir,  0);
      check("rst_bit_valid",  act_bv,  0);
      check("rst_bit_out",    act_bo,  0);
      check("rst_sof",        act_sof, 0);
      check("rst_eof",        act_eof, 0);
      check("rst_frame_done", act_fd,  0);
    end else begin
      check("in_ready", act_ir, clk_enable & ((m_cnt >= spf) || (q.size() == 0) ||
                                              (bit_ready && q.size() == 1)));
      check("bit_valid", act_bv, clk_enable & (q.size() != 0));
      check("frame_done", act_fd, fd_exp);
      if (act_fd && !fd_prev) fd_pulses++;
      fd_prev = act_fd;
      if (act_bv && q.size() != 0) begin
        check("bit_out", act_bo,  q[0].b);
        check("bit_sof", act_sof, q[0].sof);
        check("bit_eof", act_eof, q[0].eof);
      end
      xfer = act_bv & bit_ready;
      acc  = in_valid & act_ir;
      if (xfer && q.size() != 0) begin
        void'(q.pop_front());
        bits_out++;
      end
      if (clk_enable) fd_exp = acc && (m_cnt == wpf - 1);
      if (acc) begin
        if (m_cnt < spf)
          for (int i = dw - 1; i >= 0; i--)
            q.push_back('{b: in_data[i], sof: (m_cnt == 0 && i == dw - 1),
                          eof: (m_cnt == spf - 1 && i == 0)});
        m_cnt = (m_cnt == wpf - 1) ? 0 : m_cnt + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    while (!act_ir && n < LIMIT) begin
      n++;
      @(negedge clk);
    end
    if (n >= LIMIT) check("send_timeout", 1, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < LIMIT) begin
      n++;
      tick();
    end
    if (n >= LIMIT) check("drain_timeout", 1, 0);
    repeat (3) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, f0;
    rst_n      = 1'b0;
    clk_enable = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    bit_ready  = 1'b1;
    sel        = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // One frame, free-running consumer.
    b0 = bits_out; f0 = fd_pulses;
    send(8'hA); send(8'h9); send(8'h3); send(8'hC);
    drain();
    check("s1_bits", bits_out - b0, 8);
    check("s1_frame_done", fd_pulses - f0, 1);

    // Two frames streamed back to back.
    b0 = bits_out; f0 = fd_pulses;
    send(8'h5); send(8'hC); send(8'hF); send(8'h0);
    send(8'h3); send(8'h6); send(8'h1); send(8'h2);
    drain();
    check("s2_bits", bits_out - b0, 16);
    check("s2_frame_done", fd_pulses - f0, 2);

    // Consumer stall on the first bit of word 0.
    b0 = bits_out; f0 = fd_pulses;
    send(8'hA);
    fork
      begin
        bit_ready = 1'b0;
        repeat (5) tick();
        bit_ready = 1'b1;
      end
      begin
        send(8'h9); send(8'h3); send(8'hC);
      end
    join
    drain();
    check("s3_bits", bits_out - b0, 8);
    check("s3_frame_done", fd_pulses - f0, 1);

    // Global stall mid-frame.
    b0 = bits_out; f0 = fd_pulses;
    fork
      begin
        repeat (3) tick();
        clk_enable = 1'b0;
        repeat (3) tick();
        clk_enable = 1'b1;
      end
      begin
        send(8'hA); send(8'h9); send(8'h3); send(8'hC);
      end
    join
    drain();
    check("s4_bits", bits_out - b0, 8);
    check("s4_frame_done", fd_pulses - f0, 1);

    // Reset after the first word of a frame; next word restarts the frame.
    send(8'hA);
    tick();
    do_reset();
    b0 = bits_out; f0 = fd_pulses;
    send(8'h5); send(8'h6); send(8'h7); send(8'h8);
    drain();
    check("s5_bits", bits_out - b0, 8);
    check("s5_frame_done", fd_pulses - f0, 1);

    // Full-size frame with random data.
    rst_n = 1'b0;
    repeat (2) tick();
    sel   = 1'b1;
    rst_n = 1'b1;
    tick();
    b0 = bits_out; f0 = fd_pulses;
    for (int w = 0; w < 2025; w++) send(8'($urandom_range(0, 255)));
    drain();
    check("s6_bits", bits_out - b0, 7200);
    check("s6_frame_done", fd_pulses - f0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
